clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 210 +++++++++++++++++++++
 tb/tb_clk_en_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: NCH phase-accumulator channels gated by a PLL-lock supervisor.
// ce is registered (one cycle after the accumulator crosses den); config updates wait for a ce boundary.
module clk_en_gen #(
  parameter int NCH        = 2,
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 1024,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic              cfg_err,
  output logic [NCH-1:0]    ce,
  output logic [NCH-1:0]    clk_div,
  output logic              running,
  output logic [7:0]        lock_loss_cnt
);

  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
  localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_lock_s1;
  logic             r_lock_s2;
  logic             w_lock;
  logic [CNT_W-1:0] r_settle_cnt;
  logic             w_settle_done;
  logic             w_in_run;
  logic             w_to_idle;
  logic [7:0]       r_lock_loss;
  logic             r_cfg_err;

  logic             w_ch_ok;
  logic             w_cfg_ok;
  logic             w_pend_sel;
  logic             w_accept;

  logic [ACC_W-1:0] r_num    [NCH];
  logic [ACC_W-1:0] r_den    [NCH];
  logic [ACC_W-1:0] r_acc    [NCH];
  logic [ACC_W-1:0] r_sh_num [NCH];
  logic [ACC_W-1:0] r_sh_den [NCH];
  logic [ACC_W-1:0] w_acc_nxt[NCH];
  logic [ACC_W:0]   w_sum    [NCH];
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_ce;
  logic [NCH-1:0]   r_clk_div;
  logic [NCH-1:0]   w_en;
  logic [NCH-1:0]   w_fire;
  logic [NCH-1:0]   w_apply;
  logic [NCH-1:0]   w_load;

  assign w_lock        = r_lock_s2;
  assign w_settle_done = (r_settle_cnt == CNT_W'(SETTLE_CYC - 1));

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // Supervisor FSM: state register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Supervisor FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_lock) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!w_lock)            w_state_nxt = ST_IDLE;
        else if (w_settle_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Supervisor FSM: outputs
  always_comb begin
    w_in_run  = (r_state == ST_RUN);
    w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if ((r_state == ST_SETTLE) && w_lock) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_lock_loss <= '0;
    end else if (w_to_idle && (r_lock_loss != 8'hFF)) begin
      r_lock_loss <= r_lock_loss + 8'd1;
    end
  end

  // Out-of-range channels report ready so the request can be taken and rejected.
  always_comb begin
    w_ch_ok    = ({1'b0, cfg_ch} < NCH_L);
    w_cfg_ok   = w_ch_ok && (cfg_den != '0) && (cfg_num <= cfg_den);
    w_pend_sel = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_ch == CH_W'(c)) w_pend_sel = r_pend[c];
    end
    cfg_ready = !w_pend_sel;
    w_accept  = cfg_valid && cfg_ready;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && !w_cfg_ok;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_en[c]      = (r_num[c] != '0);
      w_sum[c]     = {1'b0, r_acc[c]} + {1'b0, r_num[c]};
      w_fire[c]    = w_in_run && w_en[c] && (w_sum[c] >= {1'b0, r_den[c]});
      w_acc_nxt[c] = w_fire[c] ? ACC_W'(w_sum[c] - {1'b0, r_den[c]}) : w_sum[c][ACC_W-1:0];
      w_apply[c]   = r_pend[c] && (w_fire[c] || !w_en[c] || !w_in_run);
      w_load[c]    = w_accept && w_cfg_ok && (cfg_ch == CH_W'(c));
    end
  end

  // Apply and load are exclusive: a channel only accepts while nothing is pending.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_num[c]    <= '0;
        r_den[c]    <= '0;
        r_acc[c]    <= '0;
        r_sh_num[c] <= '0;
        r_sh_den[c] <= '0;
      end
      r_pend    <= '0;
      r_ce      <= '0;
      r_clk_div <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_apply[c]) begin
          r_num[c]  <= r_sh_num[c];
          r_den[c]  <= r_sh_den[c];
          r_pend[c] <= 1'b0;
        end else if (w_load[c]) begin
          r_sh_num[c] <= cfg_num;
          r_sh_den[c] <= cfg_den;
          r_pend[c]   <= 1'b1;
        end

        if (w_to_idle || !w_en[c]) begin
          r_acc[c]     <= '0;
          r_ce[c]      <= 1'b0;
          r_clk_div[c] <= 1'b0;
        end else if (w_apply[c]) begin
          r_acc[c]     <= '0;
          r_ce[c]      <= w_fire[c];
          r_clk_div[c] <= r_clk_div[c] ^ w_fire[c];
        end else if (w_in_run) begin
          r_acc[c]     <= w_acc_nxt[c];
          r_ce[c]      <= w_fire[c];
          r_clk_div[c] <= r_clk_div[c] ^ w_fire[c];
        end else begin
          r_ce[c] <= 1'b0;
        end
      end
    end
  end

  assign ce            = r_ce;
  assign clk_div       = r_clk_div;
  assign running       = w_in_run;
  assign cfg_err       = r_cfg_err;
  assign lock_loss_cnt = r_lock_loss;

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: directed scenarios plus random config/lock traffic against a rate-based model.
module tb_clk_en_gen;
  localparam int NCH    = 3;
  localparam int ACC_W  = 8;
  localparam int SETTLE = 16;

  logic             clkin     = 1'b0;
  logic             reset     = 1'b1;
  logic             pll_lock  = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_ch    = 2'd0;
  logic [ACC_W-1:0] cfg_num   = '0;
  logic [ACC_W-1:0] cfg_den   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic [NCH-1:0]   ce;
  logic [NCH-1:0]   clk_div;
  logic             running;
  logic [7:0]       lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #10 clkin = ~clkin;

  clk_en_gen #(.NCH(NCH), .ACC_W(ACC_W), .SETTLE_CYC(SETTLE)) dut (
    .clkin         (clkin),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_num       (cfg_num),
    .cfg_den       (cfg_den),
    .cfg_err       (cfg_err),
    .ce            (ce),
    .clk_div       (clk_div),
    .running       (running),
    .lock_loss_cnt (lock_loss_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: lock history as a streak counter, channels as "n steps since start"
  // with a ce whenever floor(n*num/den) advances.
  bit [NCH-1:0] m_ce, m_clk, m_pend;
  bit           m_err, mrun, lp1, lp2;
  int           mlost, streak;
  int           m_num[NCH], m_den[NCH], m_snum[NCH], m_sden[NCH];
  longint       m_n[NCH];
  bit           t_sync, t_to_idle, t_run, t_ready, t_ok, t_fire, t_apply, t_dis;

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      m_ce = '0; m_clk = '0; m_pend = '0; m_err = 0; mrun = 0;
      lp1 = 0; lp2 = 0; mlost = 0; streak = 0;
      for (int c = 0; c < NCH; c++) begin
        m_num[c] = 0; m_den[c] = 0; m_snum[c] = 0; m_sden[c] = 0; m_n[c] = 0;
      end
    end else begin
      t_run  = mrun;
      t_sync = lp2;
      lp2    = lp1;
      lp1    = pll_lock;
      t_to_idle = (streak > 0) && !t_sync;
      if (t_to_idle && mlost < 255) mlost++;
      streak = t_sync ? streak + 1 : 0;
      mrun   = (streak > SETTLE);
      t_ready = (int'(cfg_ch) >= NCH) || !m_pend[cfg_ch];
      t_ok    = (int'(cfg_ch) < NCH) && (cfg_den != 0) && (cfg_num <= cfg_den);
      m_err   = cfg_valid && t_ready && !t_ok;
      for (int c = 0; c < NCH; c++) begin
        t_dis   = (m_num[c] == 0);
        t_fire  = t_run && !t_dis &&
                  (((m_n[c] + 1) * m_num[c]) / m_den[c] > (m_n[c] * m_num[c]) / m_den[c]);
        t_apply = m_pend[c] && (t_fire || t_dis || !t_run);
        if (t_to_idle || t_dis) begin
          m_n[c] = 0; m_ce[c] = 0; m_clk[c] = 0;
        end else if (t_apply) begin
          m_n[c] = 0; m_ce[c] = t_fire; m_clk[c] = m_clk[c] ^ t_fire;
        end else if (t_run) begin
          m_n[c] = m_n[c] + 1; m_ce[c] = t_fire; m_clk[c] = m_clk[c] ^ t_fire;
        end else begin
          m_ce[c] = 0;
        end
        if (t_apply) begin
          m_num[c] = m_snum[c]; m_den[c] = m_sden[c]; m_pend[c] = 0;
        end else if (cfg_valid && t_ready && t_ok && int'(cfg_ch) == c) begin
          m_snum[c] = int'(cfg_num); m_sden[c] = int'(cfg_den); m_pend[c] = 1;
        end
      end
    end
  end

  always @(negedge clkin) begin
    if (chk_en) begin
      #5;
      check("cmp_running", int'(running), int'(mrun));
      check("cmp_ce", int'(ce), int'(m_ce));
      check("cmp_clk_div", int'(clk_div), int'(m_clk));
      check("cmp_lock_loss", int'(lock_loss_cnt), mlost);
      check("cmp_cfg_err", int'(cfg_err), int'(m_err));
      check("cmp_cfg_ready", int'(cfg_ready),
            (int'(cfg_ch) >= NCH) ? 1 : int'(!m_pend[cfg_ch]));
    end
  end

  task automatic tick();
    @(negedge clkin);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int num, input int den, output int waited);
    tick();
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_num   = ACC_W'(num);
    cfg_den   = ACC_W'(den);
    waited    = 0;
    #1;
    while (!cfg_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (!cfg_ready) check("cfg_write_timeout", 0, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ce(input int ch, output int m);
    m = 0;
    do begin
      tick();
      m++;
    end while (!ce[ch] && m < 64);
    if (!ce[ch]) check("wait_ce_timeout", 0, 1);
  endtask

  task automatic wait_running(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!running && n < 200);
    if (!running) check("wait_running_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, n, m, cnt, bad, last, tog;
    bit prev;

    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();
    check("rst_running", int'(running), 0);
    check("rst_ce", int'(ce), 0);
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_lock_loss", int'(lock_loss_cnt), 0);

    // ch0 at 1/4, then lock
    cfg_write(0, 1, 4, w);
    tick();
    pll_lock = 1'b1;
    wait_running(n);
    check("settle_latency", n - 1, 2 + SETTLE);
    wait_ce(0, m);
    check("first_ce_1_4", m, 4);
    wait_ce(0, m);
    check("ce_spacing_1_4_a", m, 4);
    wait_ce(0, m);
    check("ce_spacing_1_4_b", m, 4);
    tog  = 0;
    prev = clk_div[0];
    repeat (16) begin
      tick();
      if (clk_div[0] != prev) tog++;
      prev = clk_div[0];
    end
    check("clk_div_toggles_16", tog, 4);

    // ch1 at 3/8 over 800 cycles
    cfg_write(1, 3, 8, w);
    tick();
    cnt = 0; bad = 0; last = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (ce[1]) begin
        if (last >= 0 && (i - last) != 2 && (i - last) != 3) bad++;
        last = i;
        cnt++;
      end
    end
    check("ce1_count_800", cnt, 300);
    check("ce1_bad_spacing", bad, 0);

    // one-cycle lock drop
    tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    check("drop_running_d1", int'(running), 1);
    tick();
    check("drop_running_d2", int'(running), 0);
    check("drop_ce", int'(ce), 0);
    check("drop_clk_div", int'(clk_div), 0);
    check("drop_lock_loss", int'(lock_loss_cnt), 1);
    wait_running(n);
    wait_ce(0, m);
    check("resume_first_ce", m, 4);
    wait_ce(0, m);
    check("resume_spacing", m, 4);

    // ratio change at a ce boundary, back-to-back write stalls
    cfg_write(0, 1, 8, w);
    wait_ce(0, m);
    wait_ce(0, m);
    check("ratio_1_8_spacing", m, 8);
    cfg_write(0, 1, 2, w);
    check("ready_low_pending", int'(cfg_ready), 0);
    cfg_write(0, 1, 4, w2);
    check("stalled_write_wait", w2, 5);
    tick();
    check("ratio_1_2_ce", int'(ce[0]), 1);
    wait_ce(0, m);
    check("ratio_1_4_again", m, 4);

    // rejected requests
    cfg_write(0, 5, 4, w);
    check("err_num_gt_den", int'(cfg_err), 1);
    tick();
    check("err_one_cycle", int'(cfg_err), 0);
    cfg_write(0, 1, 0, w);
    check("err_den_zero", int'(cfg_err), 1);
    cfg_write(3, 1, 2, w);
    check("err_bad_channel", int'(cfg_err), 1);
    wait_ce(0, m);
    wait_ce(0, m);
    check("spacing_after_err", m, 4);

    // lock_loss_cnt saturation
    for (int i = 0; i < 260; i++) begin
      tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
    end
    repeat (4) tick();
    check("lock_loss_sat", int'(lock_loss_cnt), 255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      cfg_valid = ($urandom % 3 == 0);
      cfg_ch    = 2'($urandom % 4);
      cfg_den   = ACC_W'($urandom_range(0, 12));
      cfg_num   = ACC_W'($urandom_range(0, 14));
      pll_lock  = ($urandom % 300 != 0);
    end
    tick();
    cfg_valid = 1'b0;
    pll_lock  = 1'b1;

    // asynchronous reset mid-RUN
    wait_running(n);
    cfg_write(0, 1, 1, w);
    repeat (4) tick();
    check("pre_reset_ce0", int'(ce[0]), 1);
    tick();
    #6;
    reset = 1'b1;
    #1;
    check("async_rst_ce", int'(ce), 0);
    check("async_rst_clk_div", int'(clk_div), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_lock_loss", int'(lock_loss_cnt), 0);
    check("async_rst_cfg_err", int'(cfg_err), 0);
    tick();
    reset = 1'b0;
    wait_running(n);
    cnt = 0;
    repeat (40) begin
      tick();
      if (ce != '0 || clk_div != '0) cnt++;
    end
    check("post_reset_disabled", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
